hex_sb_ctrl: RTL and testbench
==============================

HEX_SB_CTRL -- requirements
Module: hex_sb_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1024, meaning system-clock cycles each digit is displayed per scan slot.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk_i  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  asynchronous active-high reset.
REQ-005 req_i  input  1  bus request, already qualified by the top-level address decode.
REQ-006 write_enable_i  input  1  1 = write, 0 = read; sampled only while req_i=1.
REQ-007 addr_i  input  32  byte address; only bits [5:2] SHALL be decoded.
REQ-008 write_data_i  input  32  write data.
REQ-009 read_data_o  output  32  registered read data.
REQ-010 ready_o  output  1  one-cycle response strobe for each accepted request.
REQ-011 hex_led_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 hex_sel_o  output  8  digit anodes, active-low, at most one bit low.

Function
REQ-013 Register map (word offsets):
  - 0x00..0x1C: DIGIT0..DIGIT7, RW, bits[3:0].
  - 0x20: ENABLE, RW, bits[7:0], bit n enables digit n.
  - 0x24: SWRST, WO; reads as 0.
REQ-014 Request acceptance: any cycle with req_i=1 SHALL be accepted; there are no wait states.
REQ-015 ready_o SHALL be 1 exactly in the cycle after each accepted request; back-to-back requests SHALL give back-to-back ready_o pulses.
REQ-016 A write SHALL update the target register at the accepting edge, visible on read and on the display from the next cycle.
REQ-017 A write SHALL store write_data_i masked to the register width.
REQ-018 A read SHALL load read_data_o at the accepting edge, zero-extended, with unused bits 0.
REQ-019 read_data_o SHALL hold its value until the next accepted read; writes SHALL NOT change it.
REQ-020 Unmapped offsets (0x28..0x3C): writes ignored, reads return 0, ready_o still pulses.
REQ-021 A write of any value to SWRST SHALL set all DIGITn to 0 and ENABLE to 8'hFF at that edge, without resetting the scan state.
REQ-022 Scan counter: counts 0..SCAN_DIV-1 and wraps to 0; on wrap, the slot index SHALL advance 0->1->...->7->0.
REQ-023 Slot n with ENABLE[n]=1: hex_sel_o SHALL be all ones except bit n=0, and hex_led_o SHALL be the decoded pattern of DIGITn.
REQ-024 Slot n with ENABLE[n]=0: hex_sel_o SHALL be 8'hFF and hex_led_o SHALL be 7'h7F.
REQ-025 hex_sel_o and hex_led_o SHALL be registered, lagging the slot index by one cycle, and SHALL be glitch-free.
REQ-026 Decode SHALL cover hex 0-F, active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-027 write_data_i and read_data_o SHALL be ignored/undriven by display logic; the display path SHALL read only the register file.

Reset
REQ-028 While rst_i=1, the block SHALL force: DIGITn=0, ENABLE=8'hFF, scan counter=0, slot=0, read_data_o=0, ready_o=0, hex_sel_o=8'hFF, hex_led_o=7'h7F.
REQ-029 After rst_i deasserts, hex_sel_o SHALL become 8'hFE and hex_led_o 7'h40 within one cycle.
REQ-030 Reset asserted mid-transaction SHALL suppress the pending ready_o pulse.

Structure
REQ-031 Register offsets and the SCAN_DIV default SHALL live in shared package peripheral_pkg.
REQ-032 The 4-bit-to-7-segment decode SHALL be a combinational sub-module, hex_digit_decoder.

Verification (SCAN_DIV=4)
REQ-033 Reset release -> hex_sel_o=8'hFE, hex_led_o=7'h40; a read of 0x20 -> read_data_o=32'hFF with ready_o pulsing one cycle later.
REQ-034 Write 0x5 to 0x00 and 0xA to 0x04 -> slot0 shows 7'h12, slot1 shows 7'h08 with hex_sel_o=8'hFD; each slot lasts 4 cycles, and the scan wraps after slot 7.
REQ-035 Write 0x0F to ENABLE -> slots 4-7 drive hex_sel_o=8'hFF and hex_led_o=7'h7F.
REQ-036 Write 0xFFFF_FFF3 to 0x08, then read 0x08 -> read_data_o=32'h3; a read of 0x30 -> 0 with ready_o still pulsing.
REQ-037 Set digits and ENABLE=0, then write SWRST -> all digits read 0 and ENABLE reads 8'hFF; back-to-back write then read -> two consecutive ready_o pulses.
REQ-038 Assert rst_i on the cycle after a read request -> no ready_o pulse, and all outputs take their reset values immediately.

Source files
------------

// File: rtl/peripheral_pkg.sv
// Shared register map and defaults for the memory-mapped display peripherals.
// The scan divider default also lives here so every instance starts from the same value.
package peripheral_pkg;

  localparam int SCAN_DIV_DEFAULT = 1024;
  localparam int NUM_DIGITS       = 8;

  localparam logic [31:0] DIGIT0_OFFSET = 32'h00;
  localparam logic [31:0] ENABLE_OFFSET = 32'h20;
  localparam logic [31:0] SWRST_OFFSET  = 32'h24;

  typedef enum logic [1:0] {
    REG_DIGIT  = 2'd0,
    REG_ENABLE = 2'd1,
    REG_SWRST  = 2'd2,
    REG_NONE   = 2'd3
  } reg_sel_e;

  // Classifies a word index (addr[5:2]) into the register it targets.
  function automatic reg_sel_e decode_reg(input logic [3:0] idx);
    logic [31:0] enable_off;
    logic [31:0] swrst_off;
    logic [31:0] digit_off;
    enable_off = ENABLE_OFFSET;
    swrst_off  = SWRST_OFFSET;
    digit_off  = DIGIT0_OFFSET;
    if (idx >= digit_off[5:2] && idx < enable_off[5:2]) begin
      decode_reg = REG_DIGIT;
    end else if (idx == enable_off[5:2]) begin
      decode_reg = REG_ENABLE;
    end else if (idx == swrst_off[5:2]) begin
      decode_reg = REG_SWRST;
    end else begin
      decode_reg = REG_NONE;
    end
  endfunction

endpackage

// File: rtl/hex_digit_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_digit_decoder (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (digit_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_sb_ctrl.sv
// Eight-digit multiplexed hex display behind a simple bus: digit/enable registers,
// a scan divider stepping through slots, and registered active-low segment/anode outputs.
module hex_sb_ctrl
  import peripheral_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic [6:0]  hex_led_o,
  output logic [7:0]  hex_sel_o
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  // Handshake: every cycle with req_i=1 is accepted at that rising edge (no wait
  // states); ready_o is high for exactly the following cycle, so back-to-back
  // requests give back-to-back ready pulses. Read data is valid while ready_o=1
  // and held until the next accepted read.

  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic [7:0]                 enable_q, enable_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       ready_q, ready_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [2:0]                 slot_q, slot_d;
  logic [7:0]                 sel_q, sel_d;
  logic [6:0]                 led_q, led_d;

  logic [3:0] reg_idx;
  reg_sel_e   reg_sel;
  logic [3:0] slot_digit;
  logic [6:0] slot_seg;

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:6], addr_i[1:0], write_data_i[31:8]};

  assign reg_idx    = addr_i[5:2];
  assign reg_sel    = decode_reg(reg_idx);
  assign slot_digit = digit_q[slot_q];

  hex_digit_decoder u_dec (
    .digit_i (slot_digit),
    .seg_o   (slot_seg)
  );

  always_comb begin
    digit_d  = digit_q;
    enable_d = enable_q;
    rdata_d  = rdata_q;
    ready_d  = req_i;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    sel_d    = 8'hFF;
    led_d    = 7'h7F;

    if (req_i) begin
      if (write_enable_i) begin
        case (reg_sel)
          REG_DIGIT:  digit_d[reg_idx[2:0]] = write_data_i[3:0];
          REG_ENABLE: enable_d = write_data_i[7:0];
          REG_SWRST: begin
            digit_d  = '0;
            enable_d = 8'hFF;
          end
          default: ;
        endcase
      end else begin
        case (reg_sel)
          REG_DIGIT:  rdata_d = {28'd0, digit_q[reg_idx[2:0]]};
          REG_ENABLE: rdata_d = {24'd0, enable_q};
          default:    rdata_d = 32'd0;
        endcase
      end
    end

    if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      slot_d = slot_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs are recomputed from the current slot every cycle and registered,
    // so the pins never see decode glitches.
    if (enable_q[slot_q]) begin
      sel_d = ~(8'd1 << slot_q);
      led_d = slot_seg;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digit_q  <= '0;
      enable_q <= 8'hFF;
      rdata_q  <= 32'd0;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
      slot_q   <= 3'd0;
      sel_q    <= 8'hFF;
      led_q    <= 7'h7F;
    end else begin
      digit_q  <= digit_d;
      enable_q <= enable_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      sel_q    <= sel_d;
      led_q    <= led_d;
    end
  end

  assign read_data_o = rdata_q;
  assign ready_o     = ready_q;
  assign hex_sel_o   = sel_q;
  assign hex_led_o   = led_q;

endmodule

// File: tb/tb_hex_sb_ctrl.sv
// Directed bench for hex_sb_ctrl with a short scan period so slot timing is observable.
module tb_hex_sb_ctrl;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [6:0]  led;
  logic [7:0]  sel;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  hex_sb_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .write_enable_i (we),
    .addr_i         (addr),
    .write_data_i   (wdata),
    .read_data_o    (rdata),
    .ready_o        (ready),
    .hex_led_o      (led),
    .hex_sel_o      (sel)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks: start and end on a falling edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    check_eq("wr_ready", {31'd0, ready}, 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    check_eq({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check_eq(tag, rdata, exp_q.pop_front());
  endtask

  // Waits for the first cycle of a slot showing anode pattern s.
  task automatic wait_slot(input logic [7:0] s, input string tag);
    int i;
    i = 0;
    while (sel == s && i < 64) begin @(negedge clk); i++; end
    while (sel != s && i < 128) begin @(negedge clk); i++; end
    check_eq(tag, {24'd0, sel}, {24'd0, s});
  endtask

  task automatic run_len(input logic [7:0] s, output int n);
    n = 0;
    while (sel == s && n < 64) begin n++; @(negedge clk); end
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_sel", {24'd0, sel}, 32'hFF);
    check_eq("rst_led", {25'd0, led}, 32'h7F);
    check_eq("rst_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_sel", {24'd0, sel}, 32'hFE);
    check_eq("rel_led", {25'd0, led}, 32'h40);

    // enable reset value and single-cycle ready
    bus_read(32'h20, 32'hFF, "rd_enable_rst");
    @(negedge clk);
    check_eq("ready_drop", {31'd0, ready}, 32'd0);

    // digit display, slot length and wrap
    bus_write(32'h00, 32'h5);
    bus_write(32'h04, 32'hA);
    wait_slot(8'hFD, "wait_slot1");
    check_eq("slot1_led", {25'd0, led}, 32'h08);
    run_len(8'hFD, n);
    check_eq("slot1_len", n, 4);
    check_eq("slot2_sel", {24'd0, sel}, 32'hFB);
    check_eq("slot2_led", {25'd0, led}, 32'h40);
    wait_slot(8'h7F, "wait_slot7");
    run_len(8'h7F, n);
    check_eq("slot7_len", n, 4);
    check_eq("wrap_sel", {24'd0, sel}, 32'hFE);
    check_eq("wrap_led", {25'd0, led}, 32'h12);

    // disabled upper digits blank
    bus_write(32'h20, 32'h0F);
    wait_slot(8'hF7, "wait_slot3");
    run_len(8'hF7, n);
    check_eq("slot3_len", n, 4);
    n = 0; bad = 0;
    while (sel == 8'hFF && n < 64) begin
      if (led != 7'h7F) bad++;
      n++;
      @(negedge clk);
    end
    check_eq("blank_len", n, 16);
    check_eq("blank_led", bad, 0);
    check_eq("blank_wrap", {24'd0, sel}, 32'hFE);

    // masking, read hold, unmapped and write-only offsets
    bus_write(32'h08, 32'hFFFF_FFF3);
    bus_read(32'h08, 32'h3, "rd_mask");
    bus_write(32'h0C, 32'h7);
    check_eq("rd_hold", rdata, 32'h3);
    bus_read(32'h30, 32'h0, "rd_unmapped");
    bus_write(32'h28, 32'h1234);
    bus_read(32'h28, 32'h0, "rd_unmapped_wr");
    bus_read(32'h24, 32'h0, "rd_swrst");

    // software reset
    for (int i = 0; i < 8; i++) bus_write(32'(i * 4), 32'(i + 8));
    bus_read(32'h0C, 32'hB, "rd_digit3");
    bus_write(32'h20, 32'h0);
    bus_read(32'h20, 32'h0, "rd_enable0");
    bus_write(32'h24, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) bus_read(32'(i * 4), 32'h0, "rd_swrst_digit");
    bus_read(32'h20, 32'hFF, "rd_swrst_enable");

    // back-to-back write then read
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h1C; wdata = 32'h6;
    @(negedge clk);
    check_eq("b2b_ready0", {31'd0, ready}, 32'd1);
    we = 1'b0;
    @(negedge clk);
    req = 1'b0;
    check_eq("b2b_ready1", {31'd0, ready}, 32'd1);
    check_eq("b2b_rdata", rdata, 32'h6);
    @(negedge clk);
    check_eq("b2b_ready_drop", {31'd0, ready}, 32'd0);

    // reset during the response cycle
    req = 1'b1; we = 1'b0; addr = 32'h1C;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    check_eq("midrst_ready", {31'd0, ready}, 32'd0);
    check_eq("midrst_sel", {24'd0, sel}, 32'hFF);
    check_eq("midrst_led", {25'd0, led}, 32'h7F);
    check_eq("midrst_rdata", rdata, 32'd0);
    rst = 1'b0;
    bus_read(32'h1C, 32'h0, "rd_after_rst");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
